// File: rtl/priority_encoder_16to4_if.sv
// Output handshake of the 16:4 priority encoder.
// Master drives the index and valid, slave returns ready.
interface priority_encoder_16to4_if;
    logic [3:0] F;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output F,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  F,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/priority_encoder_16to4.sv
// Sequential 16:4 priority encoder with pending-request latching.
// Issues the highest pending index over a registered valid/ready stage.
module priority_encoder_16to4 (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [15:0]                    D,
    priority_encoder_16to4_if.master       out_if,
    output logic [15:0]                    pending,
    output logic [7:0]                     coalesce_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state_q, state_d;
    logic [3:0]  f_q, f_d;
    logic [15:0] pending_q, pending_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  idx;
    logic [15:0] clr;
    logic        load;
    logic        coal;

    // Ascending scan, so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (pending_q[i]) idx = 4'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        load      = (pending_q != '0) &&
                    (state_q == EMPTY || out_if.out_ready);
        clr       = load ? (16'h0001 << idx) : '0;
        pending_d = (pending_q & ~clr) | D;
        coal      = (D & pending_q & ~clr) != '0;
        cnt_d     = (coal && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        if (load) f_d = idx;
        unique case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (out_if.out_ready && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            f_q       <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_if.F         = f_q;
    assign out_if.out_valid = (state_q == FULL);
    assign pending          = pending_q;
    assign coalesce_cnt     = cnt_q;
endmodule
